// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access sizes and
// the legality check used when a request is accepted.
package load_store_unit_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  localparam int TIMEOUT_DEFAULT = 255;

  // A size is legal only if it is one of the three encodings and the
  // address is naturally aligned for it.
  function automatic logic access_ok(input logic [3:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    access_ok = 1'b1;
      SZ_H:    access_ok = ~addr_lo[0];
      SZ_W:    access_ok = (addr_lo == 2'b00);
      default: access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: byte enables, store data shift and load data
// realignment with zeroing of bytes outside the access size.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_right
);

  logic [4:0]  shamt;
  logic [31:0] mask;

  assign shamt       = {addr_lo, 3'b000};
  assign be          = size << addr_lo;
  assign wdata_lane  = wdata << shamt;
  assign mask        = {{8{size[3]}}, {8{size[2]}}, {8{size[1]}}, {8{size[0]}}};
  assign rdata_right = (rdata >> shamt) & mask;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, runs a single
// valid/ready bus transaction with a timeout, and reports done/fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  iobytes,
  output logic [31:0] memout,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic        bus_valid,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q;
  logic [7:0]  wait_q;
  logic        fault_q;
  logic [31:0] memout_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  size_q;
  logic        we_q;

  logic        req_ok;
  logic        accept;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign req_ok = (mem_read ^ mem_write) && access_ok(iobytes, addr[1:0]);
  assign accept = (state_q == IDLE) && start && req_ok;

  lsu_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .wdata       (wdata_q),
    .rdata       (bus_rdata),
    .be          (lane_be),
    .wdata_lane  (lane_wdata),
    .rdata_right (lane_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      wait_q   <= 8'd0;
      fault_q  <= 1'b0;
      memout_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          fault_q <= 1'b0;
          if (start) begin
            if (req_ok) begin
              state_q <= BUS;
              wait_q  <= 8'd0;
            end else begin
              state_q <= DONE;
              fault_q <= 1'b1;
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            state_q <= DONE;
            fault_q <= 1'b0;
            if (!we_q) memout_q <= lane_rdata;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= DONE;
            fault_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: request payload registers carry no reset; they are only observed
  // while in BUS, which is reachable solely through a load of these registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      size_q  <= iobytes;
      we_q    <= mem_write;
    end
  end

  assign bus_valid = (state_q == BUS);
  assign bus_we    = bus_valid & we_q;
  assign bus_be    = bus_valid ? lane_be : 4'b0000;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = lane_wdata;
  assign done      = (state_q == DONE);
  assign fault     = fault_q;
  assign busy      = bus_valid | ((state_q == IDLE) & start);
  assign memout    = memout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: aligned loads/stores,
// wait states, misalignment and illegal requests, timeout and reset mid-bus.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [3:0]  iobytes;
  logic [31:0] memout;
  logic        busy, done, fault;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_we, bus_valid, bus_ready;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .iobytes   (iobytes),
    .memout    (memout),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_we    (bus_we),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] sz);
    start = 1'b1; mem_read = rd; mem_write = wr;
    addr = a; wdata = wd; iobytes = sz;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Request rejected in IDLE: done+fault on the very next cycle, no bus activity.
  task automatic expect_reject(input string tag);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_valid0"}, 32'(bus_valid), 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_fault"}, 32'(fault), 32'd1);
    check({tag, "_valid1"}, 32'(bus_valid), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int guard;

    rst = 1'b0; idle_inputs();
    addr = 32'd0; wdata = 32'd0; iobytes = 4'b0000;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_we", 32'(bus_we), 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memout", memout, 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Byte load at 0x1003, ready on the first BUS cycle.
    issue(1'b1, 1'b0, 32'h0000_1003, 32'd0, 4'b0001);
    @(negedge clk);
    check("bl_busy_start", 32'(busy), 32'd1);
    check("bl_valid_n", 32'(bus_valid), 32'd0);
    next_cycle();
    idle_inputs(); bus_ready = 1'b1; bus_rdata = 32'hAABB_CCDD;
    @(negedge clk);
    check("bl_valid", 32'(bus_valid), 32'd1);
    check("bl_addr", bus_addr, 32'h0000_1000);
    check("bl_be", 32'(bus_be), 32'b1000);
    check("bl_we", 32'(bus_we), 32'd0);
    check("bl_busy_bus", 32'(busy), 32'd1);
    check("bl_done_n1", 32'(done), 32'd0);
    next_cycle();
    bus_ready = 1'b0; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    check("bl_done", 32'(done), 32'd1);
    check("bl_fault", 32'(fault), 32'd0);
    check("bl_valid_off", 32'(bus_valid), 32'd0);
    check("bl_busy_done", 32'(busy), 32'd0);
    check("bl_memout", memout, 32'h0000_00AA);
    next_cycle();
    @(negedge clk);
    check("bl_done_off", 32'(done), 32'd0);
    check("bl_memout_hold", memout, 32'h0000_00AA);

    // Half store at 0x2002, three wait states; a start mid-transaction is ignored.
    issue(1'b0, 1'b1, 32'h0000_2002, 32'h0000_1234, 4'b0011);
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus_ready = (i == 3);
      if (i == 1) issue(1'b1, 1'b0, 32'h0000_9000, 32'hFFFF_FFFF, 4'b1111);
      @(negedge clk);
      check($sformatf("hs_valid%0d", i), 32'(bus_valid), 32'd1);
      check($sformatf("hs_addr%0d", i), bus_addr, 32'h0000_2000);
      check($sformatf("hs_be%0d", i), 32'(bus_be), 32'b1100);
      check($sformatf("hs_wdata%0d", i), bus_wdata, 32'h1234_0000);
      check($sformatf("hs_we%0d", i), 32'(bus_we), 32'd1);
      next_cycle();
      idle_inputs();
    end
    bus_ready = 1'b0;
    @(negedge clk);
    check("hs_done", 32'(done), 32'd1);
    check("hs_fault", 32'(fault), 32'd0);
    check("hs_memout_kept", memout, 32'h0000_00AA);
    next_cycle();
    @(negedge clk);
    check("hs_ignored_start", 32'(bus_valid), 32'd0);
    check("hs_idle_done", 32'(done), 32'd0);

    // Half load at 0x5002 and word load at 0x6000, both ready immediately.
    issue(1'b1, 1'b0, 32'h0000_5002, 32'd0, 4'b0011);
    next_cycle();
    idle_inputs(); bus_ready = 1'b1; bus_rdata = 32'h1234_ABCD;
    @(negedge clk);
    check("hl_be", 32'(bus_be), 32'b1100);
    next_cycle();
    bus_ready = 1'b0;
    @(negedge clk);
    check("hl_memout", memout, 32'h0000_1234);
    next_cycle();
    issue(1'b1, 1'b0, 32'h0000_6000, 32'd0, 4'b1111);
    next_cycle();
    idle_inputs(); bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wl_be", 32'(bus_be), 32'b1111);
    next_cycle();
    bus_ready = 1'b0;
    @(negedge clk);
    check("wl_memout", memout, 32'hDEAD_BEEF);
    next_cycle();

    // Rejected requests: misaligned word/half, both directions, illegal size.
    issue(1'b1, 1'b0, 32'h0000_3001, 32'd0, 4'b1111);
    expect_reject("mis_word");
    issue(1'b1, 1'b0, 32'h0000_3003, 32'd0, 4'b0011);
    expect_reject("mis_half");
    issue(1'b1, 1'b1, 32'h0000_3000, 32'd0, 4'b1111);
    expect_reject("both_dir");
    issue(1'b1, 1'b0, 32'h0000_3000, 32'd0, 4'b0111);
    expect_reject("bad_size");
    @(negedge clk);
    check("rej_fault_clear", 32'(fault), 32'd0);
    check("rej_memout_kept", memout, 32'hDEAD_BEEF);

    // Word load with bus_ready held low: timeout after 255 BUS cycles.
    next_cycle();
    issue(1'b1, 1'b0, 32'h0000_4000, 32'd0, 4'b1111);
    next_cycle();
    idle_inputs();
    vcnt = 0;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 400) begin
      if (bus_valid) vcnt++;
      guard++;
      next_cycle();
      @(negedge clk);
    end
    check("to_done", 32'(done), 32'd1);
    check("to_bus_cycles", 32'(vcnt), 32'd255);
    check("to_fault", 32'(fault), 32'd1);
    check("to_valid_off", 32'(bus_valid), 32'd0);
    check("to_memout_kept", memout, 32'hDEAD_BEEF);
    next_cycle();

    // Reset asserted during BUS while bus_ready is high.
    issue(1'b1, 1'b0, 32'h0000_7001, 32'd0, 4'b0001);
    next_cycle();
    idle_inputs(); rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rb_valid_pre", 32'(bus_valid), 32'd1);
    next_cycle();
    rst = 1'b1; bus_ready = 1'b0;
    @(negedge clk);
    check("rb_valid", 32'(bus_valid), 32'd0);
    check("rb_done", 32'(done), 32'd0);
    check("rb_memout", memout, 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rb_done_after", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
